sram16_bus_target: RTL and testbench
====================================

// Module: sram16_bus_target
// PURPOSE
//  Responder (target) side of the CPU valid/ready memory bus: accepts 32-bit word requests and
//  serves each as two 16-bit accesses to an asynchronous external SRAM (low half, then high).
//  Sits between the rv32im core's bus port and the board SRAM pins; one outstanding request.
// PARAMETERS
//  SRAM_AW      18  SRAM halfword address width; sram_a = {bus_addr[SRAM_AW:2], phase}
//  WAIT_STATES  2   extra cycles per strobe; strobe (oe_n/we_n low) lasts WAIT_STATES+1 cycles
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, asynchronous, active-high
//  bus_addr    in   32       byte address; [1:0] ignored (word access)
//  bus_wdata   in   32       write data
//  bus_rdata   out  32       read data, valid while bus_ready=1
//  bus_wr      in   1        1=write, 0=read
//  bus_lane    in   4        byte enables, writes only
//  bus_valid   in   1        request; initiator holds addr/wdata/wr/lane stable until ready
//  bus_ready   out  1        one-cycle completion pulse
//  sram_a      out  SRAM_AW  halfword address
//  sram_dq_o   out  16       write data to pad
//  sram_dq_i   in   16       read data from pad
//  sram_dq_oe  out  1        pad output enable
//  sram_ce_n / sram_oe_n / sram_we_n / sram_lb_n / sram_ub_n  out  1 each  active-low strobes
// BEHAVIOUR
//  Reset: ce_n=oe_n=we_n=lb_n=ub_n=1, dq_oe=0, sram_a=0, dq_o=0, bus_ready=0, bus_rdata=0, IDLE.
//  Async reset mid-access: strobes deassert immediately; partial write is permitted; IDLE after.
//  All outputs registered. FSM: IDLE -> SETUP -> STROBE -> HOLD -> (phase0: SETUP | phase1: DONE) -> IDLE.
//  IDLE: on bus_valid=1, latch addr/wdata/wr/lane; phase=0 -> SETUP. Bus inputs ignored after that.
//  SETUP (1 cyc): ce_n=0, sram_a set; writes: dq_oe=1, dq_o=half of wdata, lb_n/ub_n from lanes.
//  STROBE (WAIT_STATES+1 cyc, down-counter): read oe_n=0; write we_n=0.
//    Read samples sram_dq_i on the last STROBE edge.
//  HOLD (1 cyc): oe_n=we_n=1, addr/data/dq_oe held; then dq_oe=0 (on exit from phase 1).
//  Phase0: wdata[15:0], lb_n=~lane[0], ub_n=~lane[1]. Phase1: wdata[31:16], lb_n=~lane[2], ub_n=~lane[3].
//  Reads ignore bus_lane (may be stale): lb_n=ub_n=0, full word always read.
//  DONE (1 cyc): bus_ready=1; ce_n=1. bus_rdata = {phase1 half, phase0 half} on reads.
//    bus_rdata is unchanged by writes and held until the next read completes.
//  Latency: ready high 2*(WAIT_STATES+3)+1 cycles after the accept edge (11 at default).
//  Handshake: ready never high two consecutive cycles. The initiator drops valid on the edge
//    that sees ready. DONE->IDLE, and IDLE samples valid on the following edge.
//    valid held past ready therefore is a new request (initiator's responsibility).
//  lane=0000 write: both phases run with lb_n=ub_n=1 (no SRAM change).
// CONFIGURATION
//  SRAM16_SKIP_IDLE_HALF_EN defined: a write phase whose two lane bits are 00 is skipped entirely.
//    Single-half writes then take WAIT_STATES+3 phase cycles, and ready comes 6 cycles after accept at default.
//    lane=0000 goes IDLE->DONE, with ready on the 2nd cycle.
//    Reads are never skipped.
//  Undefined: both phases always run, as described above.
// TESTING
//  1 rst=1 mid-run -> ce_n/oe_n/we_n/lb_n/ub_n=1, dq_oe=0, bus_ready=0; released -> IDLE, no strobes.
//  2 Write 0x12345678 to addr 0x100, lane 1111, WAIT_STATES=2.
//    -> we_n low 3 cyc at sram_a 0x80 dq 0x5678, then 0x81 dq 0x1234.
//    -> ready 11 cyc after accept, 1 cyc wide.
//  3 Read 0x100 with lane=0000 (stale) -> lb_n=ub_n=0 both phases, bus_rdata=0x12345678 with ready.
//  4 SB 0xAB to 0x103: wdata 0xABABABAB, lane 1000.
//    -> phase0 lb_n=ub_n=1; phase1 ub_n=0, lb_n=1; readback 0xAB345678.
//    -> with SKIP_EN: only phase1 strobes, ready 6 cyc after accept.
//  5 Hold valid 1 cyc after ready, then drop -> exactly one extra access.
//    Hold valid 0 after ready -> no access; ready never 2 consecutive cycles.
//  6 Assert rst during phase0 STROBE of a write -> we_n=1 immediately.
//    After release, a read of 0x100 completes normally.

Source files
------------

// File: rtl/sram16_bus_target.sv
// sram16_bus_target
//   Target side of the CPU valid/ready memory bus. Each 32-bit word request is served as two
//   16-bit accesses to an asynchronous external SRAM: low half (phase 0), then high half (phase 1).
//   One outstanding request. All outputs are registered and lag the FSM state by one cycle, so
//   the pins show SETUP/STROBE/HOLD timing exactly as decoded from state_q.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   bus_addr/wdata/wr/lane    request fields, latched when a request is accepted in IDLE
//   bus_valid / bus_ready     request / one-cycle completion pulse
//   bus_rdata                 read data, valid while bus_ready=1, held until the next read
//   sram_a                    halfword address {bus_addr[SRAM_AW:2], phase}
//   sram_dq_o/_i/_oe          data pad out / in / output enable
//   sram_ce_n/oe_n/we_n       active-low chip, output and write strobes
//   sram_lb_n/ub_n            active-low byte selects
//
// Configuration
//   SRAM16_SKIP_IDLE_HALF_EN  when defined, a write phase with both of its lane bits clear is
//                             skipped entirely; reads always run both phases.
module sram16_bus_target #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    input  logic               bus_wr,
    input  logic [3:0]         bus_lane,
    input  logic               bus_valid,
    output logic               bus_ready,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [SRAM_AW-2:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [3:0]         lane_q, lane_d;
    logic [15:0]        rd_lo_q, rd_lo_d;
    logic [15:0]        rd_hi_q, rd_hi_d;

    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_a_q, sram_a_d;
    logic [15:0]        dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;

    logic               skip_req_lo, skip_req_hi, skip_lat_hi;
    logic               access;

    // Address bits outside the SRAM window and the byte offset are intentionally dropped.
    logic               unused_addr;
    assign unused_addr = ^{bus_addr[31:SRAM_AW+1], bus_addr[1:0]};

`ifdef SRAM16_SKIP_IDLE_HALF_EN
    assign skip_req_lo = bus_wr & (bus_lane[1:0] == 2'b00);
    assign skip_req_hi = bus_wr & (bus_lane[3:2] == 2'b00);
    assign skip_lat_hi = wr_q & (lane_q[3:2] == 2'b00);
`else
    assign skip_req_lo = 1'b0;
    assign skip_req_hi = 1'b0;
    assign skip_lat_hi = 1'b0;
`endif

    // Next-state and request latching.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        lane_d  = lane_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;

        unique case (state_q)
            StIdle: begin
                // ready_q high means the initiator may still be holding valid from the
                // request just completed; that edge is not a sampling edge.
                if (bus_valid && !ready_q) begin
                    addr_d  = bus_addr[SRAM_AW:2];
                    wdata_d = bus_wdata;
                    wr_d    = bus_wr;
                    lane_d  = bus_lane;
                    if (skip_req_lo) begin
                        phase_d = 1'b1;
                        state_d = skip_req_hi ? StDone : StSetup;
                    end else begin
                        phase_d = 1'b0;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = CntLoad;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                // Pins still show the strobe during this cycle, so the pad is sampled here.
                if (!wr_q) begin
                    if (phase_q) begin
                        rd_hi_d = sram_dq_i;
                    end else begin
                        rd_lo_d = sram_dq_i;
                    end
                end
                if (!phase_q && !skip_lat_hi) begin
                    phase_d = 1'b1;
                    state_d = StSetup;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output register inputs, decoded from the current state.
    always_comb begin
        access   = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        ce_n_d   = ~access;
        oe_n_d   = ~((state_q == StStrobe) && !wr_q);
        we_n_d   = ~((state_q == StStrobe) && wr_q);
        dq_oe_d  = access && wr_q;
        sram_a_d = sram_a_q;
        dq_o_d   = dq_o_q;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        ready_d  = (state_q == StDone);
        rdata_d  = rdata_q;

        if (access) begin
            sram_a_d = {addr_q, phase_q};
            if (wr_q) begin
                dq_o_d = phase_q ? wdata_q[31:16] : wdata_q[15:0];
                lb_n_d = phase_q ? ~lane_q[2] : ~lane_q[0];
                ub_n_d = phase_q ? ~lane_q[3] : ~lane_q[1];
            end else begin
                // Reads always fetch the full halfword; lanes may be stale.
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end

        if ((state_q == StDone) && !wr_q) begin
            rdata_d = {rd_hi_q, rd_lo_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            lane_q   <= '0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            sram_a_q <= '0;
            dq_o_q   <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            lane_q   <= lane_d;
            rd_lo_q  <= rd_lo_d;
            rd_hi_q  <= rd_hi_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            sram_a_q <= sram_a_d;
            dq_o_q   <= dq_o_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            lb_n_q   <= lb_n_d;
            ub_n_q   <= ub_n_d;
        end
    end

    assign bus_ready  = ready_q;
    assign bus_rdata  = rdata_q;
    assign sram_a     = sram_a_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram16_bus_target.sv
// tb_sram16_bus_target
//   Bench for sram16_bus_target: behavioural async SRAM on the pins, a reference word memory,
//   and a queue of expected strobes filled when each request is issued and drained by a pin
//   monitor as strobes complete. Honours SRAM16_SKIP_IDLE_HALF_EN when building expectations.
module tb_sram16_bus_target;

    localparam int unsigned AW = 18;
    localparam int unsigned WS = 2;

    logic          clk;
    logic          rst;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_wr;
    logic [3:0]    bus_lane;
    logic          bus_valid;
    logic          bus_ready;
    logic [AW-1:0] sram_a;
    logic [15:0]   sram_dq_o;
    logic [15:0]   sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_lb_n;
    logic          sram_ub_n;

    sram16_bus_target #(
        .SRAM_AW     (AW),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_wr     (bus_wr),
        .bus_lane   (bus_lane),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .sram_a     (sram_a),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM on the pins, and the bench's own reference of what it should hold.
    logic [15:0] sram_mem [1024] = '{default: '0};
    logic [15:0] ref_mem  [1024] = '{default: '0};

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_a[9:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!rst && !sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_a[9:0]][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_a[9:0]][15:8] <= sram_dq_o[15:8];
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [15:0]   dq;
        logic          lb_n;
        logic          ub_n;
        logic          dq_oe;
        logic          ce_n;
    } strobe_t;

    strobe_t     exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pin monitor: every completed strobe must match the next expected one and last WS+1 cycles.
    initial begin
        int      run_len;
        logic    prev_ready;
        strobe_t cap;
        strobe_t e;
        run_len    = 0;
        prev_ready = 1'b0;
        cap        = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len    = 0;
                prev_ready = 1'b0;
            end else begin
                if (bus_ready) check_eq("ready_one_cycle", {63'd0, prev_ready}, 64'd0);
                prev_ready = bus_ready;
                if (!sram_oe_n || !sram_we_n) begin
                    if (run_len == 0) begin
                        cap.wr    = !sram_we_n;
                        cap.a     = sram_a;
                        cap.dq    = !sram_we_n ? sram_dq_o : 16'h0;
                        cap.lb_n  = sram_lb_n;
                        cap.ub_n  = sram_ub_n;
                        cap.dq_oe = sram_dq_oe;
                        cap.ce_n  = sram_ce_n;
                    end
                    run_len++;
                end else if (run_len != 0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("strobe_unexpected", 64'(run_len), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("strobe_a%0h", e.a), {20'd0, cap, 8'(run_len)},
                                 {20'd0, e, 8'(WS + 1)});
                    end
                    run_len = 0;
                end
            end
        end
    end

    // Queue the strobes a request should produce, update the reference, return expected latency.
    task automatic push_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] lane, output int lat);
        int          nph;
        logic [1:0]  l;
        logic        run;
        logic [15:0] half;
        logic [9:0]  idx;
        strobe_t     s;
        nph = 0;
        for (int p = 0; p < 2; p++) begin
            l    = (p == 1) ? lane[3:2] : lane[1:0];
            half = (p == 1) ? wdata[31:16] : wdata[15:0];
            idx  = {addr[10:2], p[0]};
            run  = 1'b1;
`ifdef SRAM16_SKIP_IDLE_HALF_EN
            if (wr && (l == 2'b00)) run = 1'b0;
`endif
            if (run) begin
                nph++;
                s.wr    = wr;
                s.a     = {addr[AW:2], p[0]};
                s.dq    = wr ? half : 16'h0;
                s.lb_n  = wr ? ~l[0] : 1'b0;
                s.ub_n  = wr ? ~l[1] : 1'b0;
                s.dq_oe = wr;
                s.ce_n  = 1'b0;
                exp_q.push_back(s);
                if (wr && l[0]) ref_mem[idx][7:0]  = half[7:0];
                if (wr && l[1]) ref_mem[idx][15:8] = half[15:8];
            end
        end
        lat = nph * (WS + 3) + 1;
    endtask

    // Called #1 after the accept edge; counts edges until ready is seen.
    task automatic wait_ready(input string tag, input int lat, input logic wr,
                              input logic [31:0] exp_rd);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus_ready && k < 40);
        check_eq({tag, "_latency"}, 64'(k), 64'(lat));
        if (!wr) begin
            check_eq({tag, "_rdata"}, {32'd0, bus_rdata}, {32'd0, exp_rd});
            last_rd = exp_rd;
        end else begin
            check_eq({tag, "_rdata_held"}, {32'd0, bus_rdata}, {32'd0, last_rd});
        end
    endtask

    task automatic bus_req(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] lane, input bit hold_extra);
        int          lat;
        logic [31:0] exp_rd;
        exp_rd = {ref_mem[{addr[10:2], 1'b1}], ref_mem[{addr[10:2], 1'b0}]};
        push_access(wr, addr, wdata, lane, lat);
        @(posedge clk);
        #1;
        bus_valid = 1'b1;
        bus_wr    = wr;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_lane  = lane;
        @(posedge clk);  // accept edge
        #1;
        wait_ready(tag, lat, wr, exp_rd);
        @(posedge clk);  // initiator sees ready on this edge
        #1;
        if (hold_extra) begin
            // valid held one more cycle: the next sampling edge starts a second access.
            push_access(wr, addr, wdata, lane, lat);
            @(posedge clk);
            #1;
            bus_valid = 1'b0;
            wait_ready({tag, "_extra"}, lat, wr, exp_rd);
            @(posedge clk);
            #1;
        end
        bus_valid = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        check_eq({tag, "_ctl"}, {57'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
                 sram_dq_oe, bus_ready}, {57'd0, 7'b1111100});
    endtask

    // Start an access, reset while its first strobe is low, then confirm a clean IDLE.
    task automatic abort_with_reset(input string tag, input logic wr, input logic [31:0] addr);
        @(posedge clk);
        #1;
        bus_valid = 1'b1;
        bus_wr    = wr;
        bus_addr  = addr;
        bus_wdata = 32'hDEADBEEF;
        bus_lane  = 4'hF;
        repeat (4) @(posedge clk);  // accept edge plus three
        #3;
        check_eq({tag, "_strobe_low"}, {63'd0, wr ? sram_we_n : sram_oe_n}, 64'd0);
        rst       = 1'b1;
        bus_valid = 1'b0;
        #1;
        check_idle_pins({tag, "_in_reset"});
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        last_rd = '0;
        repeat (6) @(posedge clk);
        #1;
        check_idle_pins({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus_valid = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_lane  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_pins("reset");
        check_eq("reset_data", {14'd0, sram_a, sram_dq_o, bus_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_pins("idle_after_reset");

        // Reset in the middle of a read, then full word write and a stale-lane read.
        abort_with_reset("rst_mid_read", 1'b0, 32'h0000_0100);
        bus_req("write_word", 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 1'b0);
        bus_req("read_stale_lane", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);

        // Byte store to the top byte, then readback.
        bus_req("write_byte3", 1'b1, 32'h0000_0103, 32'hABAB_ABAB, 4'b1000, 1'b0);
        bus_req("read_byte3", 1'b0, 32'h0000_0100, 32'h0, 4'b1111, 1'b0);

        // Lane 0000 write changes nothing; low-half-only write to another word.
        bus_req("write_no_lane", 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        bus_req("read_no_lane", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);
        bus_req("write_low", 1'b1, 32'h0000_0208, 32'hCAFE_BEEF, 4'b0011, 1'b0);
        bus_req("read_low", 1'b0, 32'h0000_0208, 32'h0, 4'b0000, 1'b0);

        // valid held one cycle past ready -> exactly one more access.
        bus_req("hold_valid", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_idle_pins("no_access_after_drop");

        // Reset during the first write strobe, then a normal read.
        abort_with_reset("rst_mid_write", 1'b1, 32'h0000_0200);
        bus_req("read_after_rst", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check_eq("strobes_outstanding", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
